// File: rtl/cosim_seq_pkg.sv
// Shared types and constants for the co-simulation commit sequencer.
package cosim_seq_pkg;

  localparam int unsigned XLEN_MAX = 64;
  localparam int unsigned INST_LEN = 32;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2,
    HALT  = 2'd3
  } seq_state_e;

  // One buffered event; traps carry only is_trap and cause, commits carry cause=0.
  typedef struct packed {
    logic                is_trap;
    logic [XLEN_MAX-1:0] pc;
    logic [INST_LEN-1:0] inst;
    logic [XLEN_MAX-1:0] wdata;
    logic [XLEN_MAX-1:0] mstatus;
    logic                check;
    logic [XLEN_MAX-1:0] cause;
  } cosim_evt_t;

endpackage

// File: rtl/cosim_seq_fifo.sv
// Multi-enqueue, single-dequeue ring buffer with a registered head entry.
module cosim_seq_fifo
  import cosim_seq_pkg::*;
#(
  parameter  int unsigned DEPTH   = 16,
  parameter  int unsigned ENQ_MAX = 3,
  localparam int unsigned OCC_W   = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W   = $clog2(DEPTH),
  localparam int unsigned ENQ_W   = $clog2(ENQ_MAX + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [ENQ_W-1:0] enq_count,
  input  cosim_evt_t       enq_data [ENQ_MAX],
  input  logic             deq,
  output logic [OCC_W-1:0] occupancy,
  output logic [OCC_W-1:0] occ_next_c,
  output cosim_evt_t       head
);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr_n;
  logic [PTR_W-1:0] rd_ptr_n;
  cosim_evt_t       mem   [DEPTH];
  cosim_evt_t       mem_n [DEPTH];

  // Next memory image with this cycle's compacted writes, plus pointer/occupancy update.
  always_comb begin
    mem_n = mem;
    for (int k = 0; k < int'(ENQ_MAX); k++) begin
      if (k < int'(enq_count)) begin
        mem_n[wr_ptr + PTR_W'(k)] = enq_data[k];
      end
    end
    wr_ptr_n   = wr_ptr + PTR_W'(enq_count);
    rd_ptr_n   = rd_ptr + PTR_W'(deq);
    occ_next_c = occupancy + OCC_W'(enq_count) - OCC_W'(deq);
  end

  // Storage array; contents are only meaningful between rd_ptr and wr_ptr.
  always_ff @(posedge clock) begin
    mem <= mem_n;
  end

  // Pointers, occupancy and the head register (head sees same-cycle writes into an empty buffer).
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      head      <= '0;
    end else begin
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      occupancy <= occ_next_c;
      head      <= mem_n[rd_ptr_n];
    end
  end

endmodule

// File: rtl/cosim_commit_sequencer.sv
// Compacts multi-lane commit/trap trace into a single in-order event stream for the
// co-simulation checker. Optional statistics ports under macro COSIM_SEQ_STATS_EN.
module cosim_commit_sequencer
  import cosim_seq_pkg::*;
#(
  parameter  int unsigned COMMIT_WIDTH = 2,
  parameter  int unsigned XLEN         = 64,
  parameter  int unsigned DEPTH        = 16,
  localparam int unsigned OCC_W        = $clog2(DEPTH + 1)
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [COMMIT_WIDTH-1:0]      in_valid,
  input  logic [XLEN*COMMIT_WIDTH-1:0] in_pc,
  input  logic [XLEN*COMMIT_WIDTH-1:0] in_wdata,
  input  logic [XLEN*COMMIT_WIDTH-1:0] in_mstatus,
  input  logic [32*COMMIT_WIDTH-1:0]   in_inst,
  input  logic [COMMIT_WIDTH-1:0]      in_check,
  input  logic                         in_xcpt,
  input  logic [XLEN-1:0]              in_cause,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_is_trap,
  output logic [XLEN-1:0]              out_pc,
  output logic [XLEN-1:0]              out_wdata,
  output logic [XLEN-1:0]              out_mstatus,
  output logic [31:0]                  out_inst,
  output logic                         out_check,
  output logic [XLEN-1:0]              out_cause,
  input  logic                         chk_fail,
  input  logic                         fini_req,
  output logic                         fini_done,
  output logic                         halted,
  output logic                         overflow,
`ifdef COSIM_SEQ_STATS_EN
  output logic [63:0]                  stat_commits,
  output logic [31:0]                  stat_traps,
  output logic [OCC_W-1:0]             stat_max_occ,
`endif
  output logic [OCC_W-1:0]             occupancy
);

  localparam int unsigned ENQ_MAX = COMMIT_WIDTH + 1;
  localparam int unsigned ENQ_W   = $clog2(ENQ_MAX + 1);

  seq_state_e       state;
  seq_state_e       state_n;
  cosim_evt_t       lane_evt [ENQ_MAX];
  logic [ENQ_W-1:0] lane_cnt;
  logic [ENQ_W-1:0] enq_count;
  logic [OCC_W-1:0] occ_next;
  cosim_evt_t       head;
  logic             accept_ok;
  logic             drop;
  logic             hs;
  logic             fail;

  // Compact valid lanes in ascending order, then append the trap entry.
  always_comb begin
    lane_cnt = '0;
    for (int s = 0; s < int'(ENQ_MAX); s++) begin
      lane_evt[s] = '0;
    end
    for (int i = 0; i < int'(COMMIT_WIDTH); i++) begin
      if (in_valid[i]) begin
        lane_evt[lane_cnt].pc      = XLEN_MAX'(in_pc[i*XLEN +: XLEN]);
        lane_evt[lane_cnt].wdata   = XLEN_MAX'(in_wdata[i*XLEN +: XLEN]);
        lane_evt[lane_cnt].mstatus = XLEN_MAX'(in_mstatus[i*XLEN +: XLEN]);
        lane_evt[lane_cnt].inst    = in_inst[i*INST_LEN +: INST_LEN];
        lane_evt[lane_cnt].check   = in_check[i];
        lane_cnt                   = lane_cnt + ENQ_W'(1);
      end
    end
    if (in_xcpt) begin
      lane_evt[lane_cnt].is_trap = 1'b1;
      lane_evt[lane_cnt].cause   = XLEN_MAX'(in_cause);
      lane_cnt                   = lane_cnt + ENQ_W'(1);
    end
  end

  // Accept/drop decision, handshake and next-state logic.
  always_comb begin
    accept_ok = (state == RUN) && !fini_req;
    enq_count = (accept_ok && in_ready) ? lane_cnt : '0;
    drop      = accept_ok && !in_ready && ((|in_valid) || in_xcpt);
    hs        = out_valid && out_ready;
    fail      = hs && chk_fail;
    state_n   = state;
    case (state)
      RUN: begin
        if (fail)          state_n = HALT;
        else if (fini_req) state_n = DRAIN;
      end
      DRAIN: begin
        if (fail)                 state_n = HALT;
        else if (occupancy == '0) state_n = DONE;
      end
      default: state_n = state;
    endcase
  end

  cosim_seq_fifo #(
    .DEPTH   (DEPTH),
    .ENQ_MAX (ENQ_MAX)
  ) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .enq_count  (enq_count),
    .enq_data   (lane_evt),
    .deq        (hs),
    .occupancy  (occupancy),
    .occ_next_c (occ_next),
    .head       (head)
  );

  // State register and registered status/handshake outputs, computed from next-state values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= RUN;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      halted    <= 1'b0;
      overflow  <= 1'b0;
      fini_done <= 1'b0;
    end else begin
      state     <= state_n;
      out_valid <= (occ_next != '0) && ((state_n == RUN) || (state_n == DRAIN));
      in_ready  <= (state_n == RUN) && ((OCC_W'(DEPTH) - occ_next) >= OCC_W'(ENQ_MAX));
      halted    <= (state_n == HALT);
      overflow  <= overflow | drop;
      fini_done <= fini_done | ((state == DRAIN) && (occupancy == '0));
    end
  end

  // Event fields come straight from the registered head entry.
  assign out_is_trap = head.is_trap;
  assign out_pc      = XLEN'(head.pc);
  assign out_wdata   = XLEN'(head.wdata);
  assign out_mstatus = XLEN'(head.mstatus);
  assign out_inst    = head.inst;
  assign out_check   = head.check;
  assign out_cause   = XLEN'(head.cause);

`ifdef COSIM_SEQ_STATS_EN
  // Saturating event counters and occupancy high-water mark.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stat_commits <= '0;
      stat_traps   <= '0;
      stat_max_occ <= '0;
    end else begin
      if (hs && !head.is_trap && (stat_commits != '1)) stat_commits <= stat_commits + 64'd1;
      if (hs && head.is_trap && (stat_traps != '1))    stat_traps   <= stat_traps + 32'd1;
      if (occ_next > stat_max_occ)                     stat_max_occ <= occ_next;
    end
  end
`endif

endmodule

// File: tb/tb_cosim_commit_sequencer.sv
// Scoreboard bench for cosim_commit_sequencer (default parameters).
module tb_cosim_commit_sequencer;

  localparam int unsigned CW    = 2;
  localparam int unsigned XLEN  = 64;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b0;
  logic [CW-1:0]        in_valid = '0;
  logic [XLEN*CW-1:0]   in_pc = '0;
  logic [XLEN*CW-1:0]   in_wdata = '0;
  logic [XLEN*CW-1:0]   in_mstatus = '0;
  logic [32*CW-1:0]     in_inst = '0;
  logic [CW-1:0]        in_check = '0;
  logic                 in_xcpt = 1'b0;
  logic [XLEN-1:0]      in_cause = '0;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic                 out_is_trap;
  logic [XLEN-1:0]      out_pc;
  logic [XLEN-1:0]      out_wdata;
  logic [XLEN-1:0]      out_mstatus;
  logic [31:0]          out_inst;
  logic                 out_check;
  logic [XLEN-1:0]      out_cause;
  logic                 chk_fail = 1'b0;
  logic                 fini_req = 1'b0;
  logic                 fini_done;
  logic                 halted;
  logic                 overflow;
  logic [OCC_W-1:0]     occupancy;
`ifdef COSIM_SEQ_STATS_EN
  logic [63:0]          stat_commits;
  logic [31:0]          stat_traps;
  logic [OCC_W-1:0]     stat_max_occ;
`endif

  cosim_commit_sequencer #(
    .COMMIT_WIDTH (CW),
    .XLEN         (XLEN),
    .DEPTH        (DEPTH)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_pc       (in_pc),
    .in_wdata    (in_wdata),
    .in_mstatus  (in_mstatus),
    .in_inst     (in_inst),
    .in_check    (in_check),
    .in_xcpt     (in_xcpt),
    .in_cause    (in_cause),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_is_trap (out_is_trap),
    .out_pc      (out_pc),
    .out_wdata   (out_wdata),
    .out_mstatus (out_mstatus),
    .out_inst    (out_inst),
    .out_check   (out_check),
    .out_cause   (out_cause),
    .chk_fail    (chk_fail),
    .fini_req    (fini_req),
    .fini_done   (fini_done),
    .halted      (halted),
    .overflow    (overflow),
`ifdef COSIM_SEQ_STATS_EN
    .stat_commits(stat_commits),
    .stat_traps  (stat_traps),
    .stat_max_occ(stat_max_occ),
`endif
    .occupancy   (occupancy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        is_trap;
    logic [63:0] pc;
    logic [31:0] inst;
    logic [63:0] wdata;
    logic [63:0] mstatus;
    logic        check;
    logic [63:0] cause;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   hs_count = 0;
  int   hs0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] f_inst(input logic [63:0] pc);
    return pc[31:0] ^ 32'h0000_0013;
  endfunction

  function automatic logic [63:0] f_mstatus(input logic [63:0] pc);
    return {pc[62:0], 1'b1};
  endfunction

  function automatic exp_t mk_commit(input logic [63:0] pc);
    exp_t e;
    e.is_trap = 1'b0;
    e.pc      = pc;
    e.inst    = f_inst(pc);
    e.wdata   = ~pc;
    e.mstatus = f_mstatus(pc);
    e.check   = pc[2];
    e.cause   = 64'd0;
    return e;
  endfunction

  function automatic exp_t mk_trap(input logic [63:0] cause);
    exp_t e;
    e.is_trap = 1'b1;
    e.pc      = 64'd0;
    e.inst    = 32'd0;
    e.wdata   = 64'd0;
    e.mstatus = 64'd0;
    e.check   = 1'b0;
    e.cause   = cause;
    return e;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present one cycle of lanes; when expect_acc, the accepted events go to the scoreboard.
  task automatic drive(input logic [1:0] v, input logic [63:0] pc0, input logic [63:0] pc1,
                       input logic x, input logic [63:0] cause, input bit expect_acc);
    in_valid   = v;
    in_pc      = {pc1, pc0};
    in_wdata   = {~pc1, ~pc0};
    in_mstatus = {f_mstatus(pc1), f_mstatus(pc0)};
    in_inst    = {f_inst(pc1), f_inst(pc0)};
    in_check   = {pc1[2], pc0[2]};
    in_xcpt    = x;
    in_cause   = cause;
    if (expect_acc) begin
      if (v[0]) sb.push_back(mk_commit(pc0));
      if (v[1]) sb.push_back(mk_commit(pc1));
      if (x)    sb.push_back(mk_trap(cause));
    end
    step();
    in_valid = '0;
    in_xcpt  = 1'b0;
  endtask

  task automatic do_reset();
    out_ready = 1'b0;
    chk_fail  = 1'b0;
    fini_req  = 1'b0;
    reset_n   = 1'b0;
    step();
    reset_n   = 1'b1;
    sb.delete();
  endtask

  // Output monitor: every handshake pops and compares the oldest expected event.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      hs_count++;
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 64'(sb.size()), 64'd1);
      end else begin
        mon_e = sb.pop_front();
        check_eq("evt_is_trap", 64'(out_is_trap), 64'(mon_e.is_trap));
        check_eq("evt_cause", out_cause, mon_e.cause);
        if (!mon_e.is_trap) begin
          check_eq("evt_pc", out_pc, mon_e.pc);
          check_eq("evt_inst", 64'(out_inst), 64'(mon_e.inst));
          check_eq("evt_wdata", out_wdata, mon_e.wdata);
          check_eq("evt_mstatus", out_mstatus, mon_e.mstatus);
          check_eq("evt_check", 64'(out_check), 64'(mon_e.check));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) step();
    reset_n = 1'b1;

    // Reset state
    check_eq("rst_occupancy", 64'(occupancy), 64'd0);
    check_eq("rst_overflow", 64'(overflow), 64'd0);
    check_eq("rst_halted", 64'(halted), 64'd0);
    check_eq("rst_fini_done", 64'(fini_done), 64'd0);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_is_trap", 64'(out_is_trap), 64'd0);
    check_eq("rst_out_pc", out_pc, 64'd0);
    check_eq("rst_out_cause", out_cause, 64'd0);

    // Single commit on lane 1 only
    out_ready = 1'b1;
    drive(2'b10, 64'd0, 64'h8000_0004, 1'b0, 64'd0, 1'b1);
    check_eq("single_valid", 64'(out_valid), 64'd1);
    check_eq("single_occ", 64'(occupancy), 64'd1);
    step();
    check_eq("single_valid_after", 64'(out_valid), 64'd0);
    check_eq("single_hs", 64'(hs_count), 64'd1);

    // Ordering: two commits then a trap, back to back
    hs0 = hs_count;
    drive(2'b11, 64'h100, 64'h104, 1'b1, 64'd7, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check_eq("order_valid", 64'(out_valid), 64'd1);
      step();
    end
    check_eq("order_valid_after", 64'(out_valid), 64'd0);
    check_eq("order_hs", 64'(hs_count - hs0), 64'd3);

    // Backpressure: fill to 14, then one dropped push
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check_eq("bp_in_ready_hi", 64'(in_ready), 64'd1);
      drive(2'b11, 64'h1000 + 64'(16 * i), 64'h1004 + 64'(16 * i), 1'b0, 64'd0, 1'b1);
    end
    check_eq("bp_in_ready_lo", 64'(in_ready), 64'd0);
    check_eq("bp_occ_full", 64'(occupancy), 64'd14);
    check_eq("bp_overflow_pre", 64'(overflow), 64'd0);
    drive(2'b11, 64'h2000, 64'h2004, 1'b0, 64'd0, 1'b0);
    check_eq("bp_overflow", 64'(overflow), 64'd1);
    check_eq("bp_occ_hold", 64'(occupancy), 64'd14);
    hs0 = hs_count;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && occupancy != '0; c++) step();
    check_eq("bp_drain_occ", 64'(occupancy), 64'd0);
    check_eq("bp_drain_hs", 64'(hs_count - hs0), 64'd14);
    check_eq("bp_sb_empty", 64'(sb.size()), 64'd0);

    // Reset mid-run with entries buffered and overflow set
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 64'h4000 + 64'(16 * i), 64'h4008 + 64'(16 * i), 1'b0, 64'd0, 1'b1);
    end
    check_eq("mid_occ_pre", 64'(occupancy), 64'd6);
    check_eq("mid_overflow_pre", 64'(overflow), 64'd1);
    do_reset();
    check_eq("mid_occ", 64'(occupancy), 64'd0);
    check_eq("mid_overflow", 64'(overflow), 64'd0);
    check_eq("mid_out_valid", 64'(out_valid), 64'd0);
    check_eq("mid_in_ready", 64'(in_ready), 64'd1);

    // Failure on the third handshake
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 64'h3000 + 64'(16 * i), 64'h3004 + 64'(16 * i), 1'b0, 64'd0, 1'b1);
    end
    hs0 = hs_count;
    out_ready = 1'b1;
    step();
    step();
    chk_fail = 1'b1;
    step();
    chk_fail = 1'b0;
    check_eq("fail_halted", 64'(halted), 64'd1);
    check_eq("fail_out_valid", 64'(out_valid), 64'd0);
    check_eq("fail_in_ready", 64'(in_ready), 64'd0);
    check_eq("fail_occ", 64'(occupancy), 64'd3);
    check_eq("fail_hs", 64'(hs_count - hs0), 64'd3);
    drive(2'b11, 64'h3800, 64'h3804, 1'b1, 64'd2, 1'b0);
    step();
    check_eq("fail_occ_frozen", 64'(occupancy), 64'd3);
    check_eq("fail_overflow", 64'(overflow), 64'd0);
    check_eq("fail_halted_hold", 64'(halted), 64'd1);
    check_eq("fail_sb_left", 64'(sb.size()), 64'd3);
    do_reset();

    // Drain: 5 buffered, fini_req with new inputs that must be ignored
    drive(2'b11, 64'h5000, 64'h5004, 1'b0, 64'd0, 1'b1);
    drive(2'b11, 64'h5010, 64'h5014, 1'b0, 64'd0, 1'b1);
    drive(2'b01, 64'h5020, 64'h0, 1'b0, 64'd0, 1'b1);
    check_eq("drain_occ_pre", 64'(occupancy), 64'd5);
    hs0 = hs_count;
    fini_req  = 1'b1;
    out_ready = 1'b1;
    in_valid  = 2'b11;
    in_pc     = {64'h6004, 64'h6000};
    in_xcpt   = 1'b1;
    in_cause  = 64'd3;
    for (int c = 0; c < 20 && !fini_done; c++) step();
    check_eq("drain_fini_done", 64'(fini_done), 64'd1);
    check_eq("drain_hs", 64'(hs_count - hs0), 64'd5);
    check_eq("drain_sb_empty", 64'(sb.size()), 64'd0);
    check_eq("drain_occ", 64'(occupancy), 64'd0);
    check_eq("drain_overflow", 64'(overflow), 64'd0);
    repeat (3) step();
    check_eq("drain_done_hold", 64'(fini_done), 64'd1);
    check_eq("drain_out_valid", 64'(out_valid), 64'd0);
    check_eq("drain_in_ready", 64'(in_ready), 64'd0);
    fini_req = 1'b0;
    in_valid = '0;
    in_xcpt  = 1'b0;
    step();
    check_eq("drain_done_sticky", 64'(fini_done), 64'd1);
    check_eq("drain_hs_final", 64'(hs_count - hs0), 64'd5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cosim_commit_sequencer.md
# cosim_commit_sequencer

Sequencer between the core's multi-lane commit/trap trace and the single-port co-simulation checker. Each cycle it accepts up to COMMIT_WIDTH retired instructions plus an optional trap, compacts them into program order, buffers them in a ring buffer, and issues exactly one event per cycle to the checker under a valid/ready handshake. It also handles checker failure (halt) and end-of-test drain.

## Interface
- COMMIT_WIDTH, default 2: commit lanes per cycle.
- XLEN, default 64: data/PC width.
- DEPTH, default 16: buffer entries; power of two, at least 2*(COMMIT_WIDTH+1).
- OCC_W, derived as $clog2(DEPTH+1): occupancy width.

Ports:
- clock  in  1  sole clock.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  COMMIT_WIDTH  per-lane commit valid. Lane 0 is the oldest.
- in_pc, in_wdata, in_mstatus  in  XLEN*COMMIT_WIDTH  per-lane fields. Lane i occupies bits [(i+1)*XLEN-1 -: XLEN].
- in_inst  in  32*COMMIT_WIDTH  per-lane instruction word.
- in_check  in  COMMIT_WIDTH  per-lane check-enable.
- in_xcpt  in  1  trap/interrupt this cycle. It is ordered after this cycle's commits.
- in_cause  in  XLEN  trap cause.
- in_ready  out  1  the upstream may present events this cycle.
- out_valid  out  1  event available to the checker.
- out_ready  in  1  checker accepts the event.
- out_is_trap  out  1  1 = trap event, 0 = commit event.
- out_pc, out_wdata, out_mstatus  out  XLEN  commit fields.
- out_inst  out  32  instruction word.
- out_check  out  1  check flag.
- out_cause  out  XLEN  trap cause; 0 for commits.
- chk_fail  in  1  checker reports a mismatch. Sampled when out_valid & out_ready.
- fini_req  in  1  end-of-test request. Level-sensitive.
- fini_done  out  1  buffer drained after fini_req.
- halted  out  1  sequencer stopped on failure.
- overflow  out  1  sticky: an event was dropped.
- occupancy  out  OCC_W  registered entry count.

## Operation
- States: RUN, DRAIN, DONE, HALT. Reset enters RUN.
- RUN:
  - Enqueue the valid lanes, compacted, in ascending lane order.
  - If in_xcpt is set, enqueue one trap entry after them.
  - Up to COMMIT_WIDTH+1 entries are written per cycle. Dequeue happens in parallel.
- RUN → DRAIN when fini_req=1. Inputs are ignored from that cycle on.
- DRAIN → DONE when occupancy=0 and no dequeue is pending. DONE is terminal until reset.
- Any state except DONE → HALT on a handshake with chk_fail=1.
  - The failing entry is consumed.
  - In HALT, out_valid=0, in_ready=0 and halted=1, and the buffer contents are frozen.
  - HALT is terminal until reset. chk_fail has priority over fini_req in the same cycle.
- in_ready = (state==RUN) & (DEPTH - occupancy ≥ COMMIT_WIDTH+1). It is computed from registered occupancy only; the same-cycle dequeue is not counted.
- Drop rule: a valid lane or in_xcpt seen while in_ready=0 in state RUN is discarded and sets overflow. Nothing is partially enqueued.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- occupancy_next = occupancy + enq_count - deq. It never exceeds DEPTH.
- The out_* fields are driven from the head entry. They are held stable while out_valid & !out_ready.
- out_valid = (occupancy ≠ 0) & state ∈ {RUN, DRAIN}.
- Empty in_valid with in_xcpt=0: no enqueue.

## Timing
- Enqueue-to-out_valid latency: 1 cycle. An entry written at edge N is visible at the head in cycle N+1 if the buffer was empty.
- Throughput: one event per cycle at the output.
- Reset values:
  - state=RUN, occupancy=0, overflow=0, halted=0, fini_done=0, out_valid=0.
  - out_is_trap=0 and all out_* data=0.
  - in_ready=1 immediately after reset.
- fini_done rises one cycle after the DRAIN→DONE transition condition holds, and stays high.
- Reset mid-operation discards all entries and clears all flags in one cycle.

## Configuration
- COSIM_SEQ_STATS_EN:
  - Defined: adds outputs stat_commits (64-bit count of dequeued commit events), stat_traps (32-bit count of dequeued trap events) and stat_max_occ (OCC_W-bit high-water mark). All reset to 0. Counters saturate and do not wrap.
  - Undefined: these ports and registers do not exist. Sequencing behaviour is identical.

## Structure
- Package cosim_seq_pkg holds:
  - typedef cosim_evt_t: is_trap, pc, inst, wdata, mstatus, check, cause. It is parameterized via package parameter XLEN_MAX=64.
  - enum seq_state_e: RUN, DRAIN, DONE, HALT.
  - Constant INST_LEN=32.
- Sub-module cosim_seq_fifo: a multi-enqueue (up to COMMIT_WIDTH+1 per cycle), single-dequeue ring buffer of cosim_evt_t entries. It exposes occupancy, head and write ports.
- The top level holds lane compaction, the state machine, drop/overflow logic and the optional statistics.

## Test plan
- Single commit: in_valid=2'b10 (lane 1 only), pc=0x8000_0004, out_ready=1 → the next cycle has exactly one event with out_pc=0x8000_0004, then out_valid=0.
- Ordering: in_valid=2'b11 (pc 0x100 in lane 0, 0x104 in lane 1) with in_xcpt=1, cause=7 → three consecutive events: 0x100, 0x104, then trap with out_cause=7.
- Backpressure: out_ready=0 and full-width commits every cycle (DEPTH=16, COMMIT_WIDTH=2):
  - in_ready falls when occupancy reaches 14.
  - One more push sets overflow, and occupancy stays 14.
  - Release out_ready: all 14 events drain in order.
- Failure: chk_fail=1 on the 3rd handshake → halted=1 the next cycle, out_valid=0, in_ready=0, and occupancy holds its remaining value.
- Drain: 5 entries buffered, fini_req=1, out_ready=1 → new inputs are ignored, 5 events are issued, and fini_done asserts and stays high.
- Reset mid-run: reset_n=0 for one cycle with 6 entries buffered → occupancy=0, overflow=0, out_valid=0, in_ready=1 on the first cycle after release.
